axi_wr_arbiter: RTL and testbench
=================================

// Module: axi_wr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares the FIFO's single AXI4-Lite write port
//  (AW/W/B channels) among NUM_REQ local requesters in the clk_axi domain.
//  Each grant runs one complete single-beat write: AW+W issue, then B collect.
//  The B response is returned to the granted requester only.
//  Sits between producer blocks and the async FIFO's AXI write slave.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_WIDTH  32  AXI write data width (wstrb is fixed at 4 bits)
//  TIMEOUT_CYC 64  B-channel watchdog limit in cycles (used only with AXI_WR_ARB_TIMEOUT_EN)
// PORTS
//  clk_axi      in   1              AXI clock
//  axi_reset    in   1              async reset, active-high
//  req          in   NUM_REQ        per-requester write request (level)
//  req_addr     in   NUM_REQ*4      packed per-requester awaddr; slot i at [4*i +: 4]
//  req_data     in   NUM_REQ*DW     packed per-requester wdata
//  req_strb     in   NUM_REQ*4      packed per-requester wstrb
//  ack          out  NUM_REQ        one-hot, 1-cycle completion pulse
//  ack_resp     out  2              bresp for the acked requester; valid only while ack!=0
//  busy         out  1              high in every state except IDLE
//  awaddr       out  4      awvalid  out 1     awready in 1
//  wdata        out  DW     wstrb    out 4     wvalid  out 1    wready in 1
//  bresp        in   2      bvalid   in  1     bready  out 1
// BEHAVIOUR
//  Reset: all outputs 0 (awvalid, wvalid, bready, ack, ack_resp, busy, awaddr/wdata/wstrb).
//    Round-robin pointer resets to requester 0 as highest priority; state resets to IDLE.
//  FSM states: IDLE, ISSUE, RESP, ACK.
//  IDLE:  if any req bit is set, grant the first set bit at or after ptr (wrapping),
//    register that slot's addr/data/strb, and go to ISSUE. Otherwise remain in IDLE.
//  ISSUE: awvalid and wvalid both high from the first ISSUE cycle.
//    Each valid drops the cycle after its own ready was seen (tracked by aw_done/w_done).
//    AW and W may complete in the same cycle or in either order.
//    When both are done, go to RESP.
//  RESP:  bready=1. On bvalid, capture bresp and go to ACK.
//  ACK:   ack[grant]=1 and ack_resp=captured bresp for exactly 1 cycle.
//    ptr <= grant+1 mod NUM_REQ. Return to IDLE.
//  Latency: req seen at cycle 0 -> valids at cycle 1.
//    With awready, wready and bvalid all immediate: bready at cycle 2, ack at cycle 3.
//    Back-to-back grants therefore start every 4 cycles minimum.
//  Payload is registered at grant, so requester inputs may change after the grant.
//    Requester protocol: hold req until ack. A req still high after ack is a new request.
//  A req dropped mid-transaction does not abort; the write completes and ack still pulses.
//  Valid/addr/data outputs never change while valid is high and ready is low (AXI stability).
//  Starvation bound: a held req is granted within NUM_REQ transactions.
//  Async reset mid-transaction: valids and bready drop immediately and the FSM returns to IDLE.
//    No ack is issued for the aborted write.
// CONFIGURATION
//  AXI_WR_ARB_TIMEOUT_EN defined:
//    A counter runs in RESP and clears on every RESP entry.
//    If it reaches TIMEOUT_CYC with no bvalid, go to ACK with ack_resp=2'b10 (SLVERR).
//    bready drops on leaving RESP; a late bvalid is ignored.
//  AXI_WR_ARB_TIMEOUT_EN undefined: no counter; RESP waits indefinitely.
// STRUCTURE
//  Package axi_wr_arb_pkg:
//    state enum (IDLE/ISSUE/RESP/ACK);
//    RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
//    idx width function clog2(NUM_REQ).
//  Sub-module rr_arbiter: req vector + ptr in, one-hot grant + index out; purely combinational.
//  The FSM, payload registers and done flags live in this top.
// TESTING
//  1 Single req[0], addr 4'h0, data 32'hDEAD_BEEF, strb 4'hF, immediate readies, bresp 00
//      -> awvalid/wvalid at cycle 1, ack[0] with resp 00 at cycle 3.
//  2 req=4'b1111 held continuously
//      -> grant order 0,1,2,3,0; each ack one-hot for exactly 1 cycle.
//  3 wready 3 cycles after awready, and the reverse order
//      -> awvalid drops after its own handshake; RESP entered only after both handshakes.
//  4 bresp=2'b10 from slave -> ack_resp=2'b10 delivered to the granted requester only.
//  5 axi_reset asserted during RESP
//      -> bready=0 and busy=0 immediately, no ack; a new req after reset is granted normally.
//  6 With AXI_WR_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, bvalid never asserted
//      -> ack with 2'b10 exactly 16 cycles after RESP entry.

Source files
------------

// File: rtl/axi_wr_arb_pkg.sv
// ============================================================================
// Module  : axi_wr_arb_pkg
// Purpose : Shared types and constants for the AXI4-Lite write-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_wr_arbiter_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick: first set request at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               valid
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[w_idx]) begin
                valid        = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_wr_arbiter.sv
// ============================================================================
// Module  : axi_wr_arbiter
// Purpose : Round-robin sequencer sharing one AXI4-Lite write port among
//           NUM_REQ requesters. Optional B watchdog: AXI_WR_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk_axi,
    input  logic                          axi_reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*4-1:0]          req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*4-1:0]          req_strb,
    output logic [NUM_REQ-1:0]            ack,
    output logic [1:0]                    ack_resp,
    output logic                          busy,
    output logic [3:0]                    awaddr,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [3:0]                    wstrb,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready
);
    import axi_wr_arb_pkg::*;

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t                  r_state;
    state_t                  w_next;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [NUM_REQ-1:0]      r_grant;
    logic [3:0]              r_addr;
    logic [3:0]              r_strb;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [1:0]              r_bresp;
    logic [NUM_REQ-1:0]      w_arb_grant;
    logic [IDX_W-1:0]        w_arb_idx;
    logic                    w_arb_valid;
    logic                    w_aw_fin;
    logic                    w_w_fin;
    logic                    w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (r_ptr),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx),
        .valid     (w_arb_valid)
    );

    // A channel counts as finished once its handshake has happened, including this cycle.
    assign w_aw_fin = r_aw_done || (awvalid && awready);
    assign w_w_fin  = r_w_done  || (wvalid  && wready);

`ifdef AXI_WR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_to_cnt;

    always_ff @(posedge clk_axi or posedge axi_reset) begin
        if (axi_reset)
            r_to_cnt <= '0;
        else if (r_state != ST_RESP)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + CNT_W'(1);
    end

    // Fires on the last RESP cycle so ACK lands TIMEOUT_CYC cycles after RESP entry.
    assign w_timeout = (r_state == ST_RESP) && (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk_axi or posedge axi_reset) begin
        if (axi_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        ack      = '0;
        ack_resp = RESP_OKAY;
        busy     = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid)
                    w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
                if (w_aw_fin && w_w_fin)
                    w_next = ST_RESP;
            end
            ST_RESP: begin
                bready = 1'b1;
                if (bvalid || w_timeout)
                    w_next = ST_ACK;
            end
            ST_ACK: begin
                ack      = r_grant;
                ack_resp = r_bresp;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_axi or posedge axi_reset) begin
        if (axi_reset) begin
            r_ptr       <= '0;
            r_grant_idx <= '0;
            r_grant     <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_strb      <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bresp     <= RESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant_idx <= w_arb_idx;
                        r_grant     <= w_arb_grant;
                        r_addr      <= req_addr[int'(w_arb_idx)*4 +: 4];
                        r_data      <= req_data[int'(w_arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                        r_strb      <= req_strb[int'(w_arb_idx)*4 +: 4];
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (awvalid && awready)
                        r_aw_done <= 1'b1;
                    if (wvalid && wready)
                        r_w_done <= 1'b1;
                end
                ST_RESP: begin
                    if (bvalid)
                        r_bresp <= bresp;
                    else if (w_timeout)
                        r_bresp <= RESP_SLVERR;
                end
                ST_ACK: begin
                    r_ptr <= (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : r_grant_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign awaddr = r_addr;
    assign wdata  = r_data;
    assign wstrb  = r_strb;

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
// ============================================================================
// Module  : tb_axi_wr_arbiter
// Purpose : Self-checking bench for axi_wr_arbiter with a round-robin model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int TO_CYC  = 16;

    logic          clk_axi = 1'b0;
    logic          axi_reset;
    logic [3:0]    req;
    logic [15:0]   req_addr;
    logic [127:0]  req_data;
    logic [15:0]   req_strb;
    logic [3:0]    ack;
    logic [1:0]    ack_resp;
    logic          busy;
    logic [3:0]    awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_ptr  = 0;

    // Slave model: each ready/valid appears a programmable number of cycles late.
    int   aw_delay = 0;
    int   w_delay  = 0;
    int   b_delay  = 0;
    logic b_never  = 1'b0;
    int   aw_wait  = 0;
    int   w_wait   = 0;
    int   b_wait   = 0;

    axi_wr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_WIDTH  (DW),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk_axi   (clk_axi),
        .axi_reset (axi_reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_strb  (req_strb),
        .ack       (ack),
        .ack_resp  (ack_resp),
        .busy      (busy),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    always #5 clk_axi = ~clk_axi;

    always @(posedge clk_axi) begin
        aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
        w_wait  <= (wvalid  && !wready)  ? w_wait + 1  : 0;
        b_wait  <= (bready  && !bvalid)  ? b_wait + 1  : 0;
    end

    assign awready = (aw_wait >= aw_delay);
    assign wready  = (w_wait  >= w_delay);
    assign bvalid  = !b_never && bready && (b_wait >= b_delay);

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (((r >> ((p + k) % NUM_REQ)) & 4'b0001) != 4'b0000)
                return (p + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic wait_ack(input int limit, output int cyc, output logic [3:0] a,
                            output logic [1:0] r);
        logic seen = 1'b0;
        cyc = -1;
        a   = '0;
        r   = '0;
        for (int c = 1; c <= limit && !seen; c++) begin
            @(negedge clk_axi);
            if (ack !== 4'b0000) begin
                seen = 1'b1;
                cyc  = c;
                a    = ack;
                r    = ack_resp;
            end
        end
    endtask

    task automatic do_reset();
        axi_reset = 1'b1;
        req       = '0;
        repeat (2) @(negedge clk_axi);
        axi_reset = 1'b0;
        m_ptr     = 0;
        @(negedge clk_axi);
    endtask

    task automatic test_reset();
        axi_reset = 1'b1;
        repeat (2) @(negedge clk_axi);
        n_cmp++;
        if ({awvalid, wvalid, bready, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {awvalid, wvalid, bready, busy});
        end
        n_cmp++;
        if ({ack, ack_resp} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ack: got %b expected 0", {ack, ack_resp});
        end
        n_cmp++;
        if ({awaddr, wdata, wstrb} !== 40'b0) begin
            n_fail++;
            $display("FAIL reset_payload: got %h expected 0", {awaddr, wdata, wstrb});
        end
        axi_reset = 1'b0;
        m_ptr     = 0;
        @(negedge clk_axi);
    endtask

    task automatic test_single();
        req_addr       = 16'($urandom);
        req_data       = {$urandom, $urandom, $urandom, $urandom};
        req_strb       = 16'($urandom);
        req_addr[3:0]  = 4'h0;
        req_data[31:0] = 32'hDEAD_BEEF;
        req_strb[3:0]  = 4'hF;
        aw_delay = 0; w_delay = 0; b_delay = 0; bresp = 2'b00;
        req = 4'b0001;
        @(negedge clk_axi);
        n_cmp++;
        if ({awvalid, wvalid, busy, awaddr, wdata, wstrb} !== {3'b111, 4'h0, 32'hDEAD_BEEF, 4'hF}) begin
            n_fail++;
            $display("FAIL single_cycle1: got %b%b%b %h %h %h expected 111 0 deadbeef f",
                     awvalid, wvalid, busy, awaddr, wdata, wstrb);
        end
        @(negedge clk_axi);
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            n_fail++;
            $display("FAIL single_cycle2: got %b expected 001", {awvalid, wvalid, bready});
        end
        @(negedge clk_axi);
        n_cmp++;
        if ({ack, ack_resp} !== {4'b0001, 2'b00}) begin
            n_fail++;
            $display("FAIL single_ack: got %b/%b expected 0001/00", ack, ack_resp);
        end
        req = '0;
        @(negedge clk_axi);
        n_cmp++;
        if ({ack, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL single_after: got %b/%b expected 0000/0", ack, busy);
        end
        m_ptr = 1;
    endtask

    task automatic test_round_robin();
        int         cyc;
        logic [3:0] a;
        logic [1:0] r;
        int         g;
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            g = rr_pick(4'b1111, m_ptr);
            wait_ack(20, cyc, a, r);
            n_cmp++;
            if (a !== 4'(1 << g) || cyc != 3) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got ack %b at cycle %0d expected %b at cycle 3",
                         n, a, cyc, 4'(1 << g));
            end
            @(negedge clk_axi);
            n_cmp++;
            if (ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_pulse%0d: got %b expected 0000", n, ack);
            end
            m_ptr = (g + 1) % NUM_REQ;
        end
        req = '0;
        @(negedge clk_axi);
    endtask

    task automatic test_skew();
        int da, dw, resp_c, ack_c;
        for (int cfg = 0; cfg < 2; cfg++) begin
            da = (cfg == 0) ? 0 : 3;
            dw = (cfg == 0) ? 3 : 0;
            aw_delay = da; w_delay = dw; b_delay = 0; bresp = 2'b00;
            resp_c = 2 + imax(da, dw);
            ack_c  = resp_c + 1;
            req    = 4'b0100;
            for (int c = 1; c <= ack_c; c++) begin
                @(negedge clk_axi);
                req = '0;
                n_cmp++;
                if ({awvalid, wvalid, bready} !== {(c <= 1 + da), (c <= 1 + dw), (c == resp_c)}) begin
                    n_fail++;
                    $display("FAIL skew%0d_c%0d: got aw/w/b %b expected %b", cfg, c,
                             {awvalid, wvalid, bready},
                             {(c <= 1 + da), (c <= 1 + dw), (c == resp_c)});
                end
                if (c == ack_c) begin
                    n_cmp++;
                    if (ack !== 4'b0100) begin
                        n_fail++;
                        $display("FAIL skew%0d_ack: got %b expected 0100", cfg, ack);
                    end
                end
            end
            @(negedge clk_axi);
            m_ptr = 3;
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_slverr();
        int         cyc, g;
        logic [3:0] a;
        logic [1:0] r;
        bresp = 2'b10;
        g     = rr_pick(4'b1010, m_ptr);
        req   = 4'b1010;
        wait_ack(10, cyc, a, r);
        n_cmp++;
        if (a !== 4'(1 << g) || r !== 2'b10 || cyc != 3) begin
            n_fail++;
            $display("FAIL slverr: got %b/%b at %0d expected %b/10 at 3", a, r, cyc, 4'(1 << g));
        end
        req = '0;
        @(negedge clk_axi);
        bresp = 2'b00;
        m_ptr = (g + 1) % NUM_REQ;
    endtask

    task automatic test_reset_mid();
        int         cyc;
        logic [3:0] a;
        logic [1:0] r;
        logic       seen = 1'b0;
        b_delay = 20;
        req     = 4'b0001;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_axi);
            if (bready === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rstmid_resp: got no bready expected bready within 10 cycles");
        end
        #2;
        axi_reset = 1'b1;
        req       = '0;
        #1;
        n_cmp++;
        if ({bready, busy, awvalid, wvalid, ack} !== 8'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop: got %b expected 0", {bready, busy, awvalid, wvalid, ack});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_axi);
            if (c == 2) axi_reset = 1'b0;
            n_cmp++;
            if (ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL rstmid_noack%0d: got %b expected 0000", c, ack);
            end
        end
        b_delay = 0;
        m_ptr   = 0;
        req     = 4'b0100;
        wait_ack(10, cyc, a, r);
        n_cmp++;
        if (a !== 4'b0100 || cyc != 3) begin
            n_fail++;
            $display("FAIL rstmid_after: got %b at %0d expected 0100 at 3", a, cyc);
        end
        req = '0;
        @(negedge clk_axi);
        m_ptr = 3;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [3:0]  rv, ea, es;
            logic [31:0] ed;
            logic [1:0]  eb;
            logic        done;
            int          g, lat;
            rv = 4'($urandom_range(1, 15));
            for (int s = 0; s < NUM_REQ; s++) begin
                req_addr[4*s +: 4]   = 4'($urandom);
                req_data[32*s +: 32] = $urandom;
                req_strb[4*s +: 4]   = 4'($urandom);
            end
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3);
            eb       = 2'($urandom);
            bresp    = eb;
            g        = rr_pick(rv, m_ptr);
            ea       = req_addr[4*g +: 4];
            ed       = req_data[32*g +: 32];
            es       = req_strb[4*g +: 4];
            lat      = 3 + imax(aw_delay, w_delay) + b_delay;
            req      = rv;
            done     = 1'b0;
            for (int c = 1; c <= lat + 5 && !done; c++) begin
                @(negedge clk_axi);
                if (awvalid) begin
                    n_cmp++;
                    if (awaddr !== ea) begin
                        n_fail++;
                        $display("FAIL rnd%0d_awaddr: got %h expected %h", t, awaddr, ea);
                    end
                end
                if (wvalid) begin
                    n_cmp++;
                    if ({wdata, wstrb} !== {ed, es}) begin
                        n_fail++;
                        $display("FAIL rnd%0d_wdata: got %h/%h expected %h/%h", t, wdata, wstrb, ed, es);
                    end
                end
                if (ack !== 4'b0000) begin
                    done = 1'b1;
                    n_cmp++;
                    if (ack !== 4'(1 << g) || ack_resp !== eb || c != lat) begin
                        n_fail++;
                        $display("FAIL rnd%0d_ack: got %b/%b at %0d expected %b/%b at %0d",
                                 t, ack, ack_resp, c, 4'(1 << g), eb, lat);
                    end
                end
                if (c == 1) begin
                    req_addr = 16'($urandom);
                    req_data = {$urandom, $urandom, $urandom, $urandom};
                    req_strb = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) req = '0;
                end
            end
            if (!done) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rnd%0d_timeout: got no ack expected ack within %0d cycles", t, lat + 5);
            end
            req = '0;
            @(negedge clk_axi);
            m_ptr = (g + 1) % NUM_REQ;
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; bresp = 2'b00;
    endtask

`ifdef AXI_WR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int         cyc;
        logic [3:0] a;
        logic [1:0] r;
        b_never = 1'b1;
        req     = 4'b0010;
        wait_ack(40, cyc, a, r);
        n_cmp++;
        if (a !== 4'b0010 || r !== 2'b10 || cyc != 2 + TO_CYC) begin
            n_fail++;
            $display("FAIL timeout: got %b/%b at %0d expected 0010/10 at %0d", a, r, cyc, 2 + TO_CYC);
        end
        req = '0;
        @(negedge clk_axi);
        b_never = 1'b0;
        m_ptr   = 2;
    endtask
`endif

    initial begin
        axi_reset = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        bresp     = 2'b00;
        test_reset();
        test_single();
        test_round_robin();
        test_skew();
        test_slverr();
        test_reset_mid();
        test_random();
`ifdef AXI_WR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "bench watchdog expired");
    end

endmodule

`default_nettype wire
